// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, default word width and select-width helper shared by
// the memory sequencer blocks.
package mc_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;
   localparam int DEF_WORD_SIZE = 16;
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mc_mem_sequencer_if.sv
// mc_mem_sequencer_if: core-side request/response channel of the memory sequencer.
interface mc_mem_sequencer_if
   import mc_pkg::*;
#(
   parameter int W = DEF_WORD_SIZE
);
   logic         req_valid;
   logic         req_write;
   logic         req_is_fetch;
   logic [W-1:0] req_addr;
   logic [W-1:0] req_wdata;
   logic         req_ready;
   logic         rsp_valid;
   logic         rsp_err;
   logic [W-1:0] rsp_rdata;
   modport master (
      output req_valid, req_write, req_is_fetch, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );
   modport slave (
      input  req_valid, req_write, req_is_fetch, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/out_port_bank.sv
// out_port_bank: bank of output channels loaded by index; out-of-range selects
// match no channel and are therefore dropped.
module out_port_bank
   import mc_pkg::*;
#(
   parameter int WORD_SIZE     = DEF_WORD_SIZE,
   parameter int NUM_OUT_PORTS = 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                wwd_valid,
   input  logic [sel_width(NUM_OUT_PORTS)-1:0] wwd_sel,
   input  logic [WORD_SIZE-1:0]                wwd_data,
   output logic [NUM_OUT_PORTS*WORD_SIZE-1:0]  output_port
);
   localparam int SW = sel_width(NUM_OUT_PORTS);
   logic [NUM_OUT_PORTS-1:0][WORD_SIZE-1:0] r_ch;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ch <= '0;
      else for (int k = 0; k < NUM_OUT_PORTS; k++)
         if (wwd_valid && wwd_sel == SW'(k)) r_ch[k] <= wwd_data;
   end
   assign output_port = r_ch;
endmodule

// File: rtl/mc_mem_sequencer.sv
// mc_mem_sequencer: single-outstanding memory access sequencer with a wait
// timeout, an instruction-fetch counter and an output-channel bank.
module mc_mem_sequencer
   import mc_pkg::*;
#(
   parameter int WORD_SIZE     = DEF_WORD_SIZE,
   parameter int NUM_OUT_PORTS = 1,
   parameter int TIMEOUT       = 15
) (
   input  logic                                clk,
   input  logic                                reset_n,
   mc_mem_sequencer_if.slave                   core,
   output logic                                read_m,
   output logic                                write_m,
   output logic [WORD_SIZE-1:0]                address,
   inout  wire  [WORD_SIZE-1:0]                data,
   input  logic                                mem_ready,
   input  logic                                wwd_valid,
   input  logic [sel_width(NUM_OUT_PORTS)-1:0] wwd_sel,
   input  logic [WORD_SIZE-1:0]                wwd_data,
   output logic [NUM_OUT_PORTS*WORD_SIZE-1:0]  output_port,
   output logic [WORD_SIZE-1:0]                num_inst
);
   state_t               r_state;
   logic [WORD_SIZE-1:0] r_wdata;
   logic [WORD_SIZE-1:0] r_address;
   logic [WORD_SIZE-1:0] r_rdata;
   logic [WORD_SIZE-1:0] r_num_inst;
   logic                 r_fetch;
   logic                 r_read_m;
   logic                 r_write_m;
   logic                 r_rsp_valid;
   logic                 r_rsp_err;
   logic [7:0]           r_cnt;
   logic                 w_timeout;
   logic                 w_done;

   // a ready on the final allowed cycle wins over the timeout
   assign w_timeout = !mem_ready && (r_cnt == 8'(TIMEOUT - 1));
   assign w_done    = mem_ready || w_timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_wdata     <= '0;
         r_address   <= '0;
         r_rdata     <= '0;
         r_num_inst  <= '0;
         r_fetch     <= 1'b0;
         r_read_m    <= 1'b0;
         r_write_m   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (core.req_valid) begin
                  r_state   <= core.req_write ? WRITE : READ;
                  r_wdata   <= core.req_wdata;
                  r_fetch   <= core.req_is_fetch;
                  r_address <= core.req_addr;
                  r_read_m  <= !core.req_write;
                  r_write_m <= core.req_write;
                  r_cnt     <= '0;
               end
            end
            READ, WRITE: begin
               if (w_done) begin
                  r_state     <= IDLE;
                  r_read_m    <= 1'b0;
                  r_write_m   <= 1'b0;
                  r_address   <= '0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_timeout;
                  if (w_timeout) r_rdata <= '0;
                  else if (r_state == READ) r_rdata <= data;
                  if (!w_timeout && r_state == READ && r_fetch) r_num_inst <= r_num_inst + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_read_m  <= 1'b0;
               r_write_m <= 1'b0;
               r_address <= '0;
            end
         endcase
      end
   end

   assign core.req_ready = (r_state == IDLE);
   assign core.rsp_valid = r_rsp_valid;
   assign core.rsp_err   = r_rsp_err;
   assign core.rsp_rdata = r_rdata;
   assign read_m         = r_read_m;
   assign write_m        = r_write_m;
   assign address        = r_address;
   assign num_inst       = r_num_inst;
   assign data           = r_write_m ? r_wdata : 'z;

   out_port_bank #(
      .WORD_SIZE     (WORD_SIZE),
      .NUM_OUT_PORTS (NUM_OUT_PORTS)
   ) u_bank (
      .clk         (clk),
      .reset_n     (reset_n),
      .wwd_valid   (wwd_valid),
      .wwd_sel     (wwd_sel),
      .wwd_data    (wwd_data),
      .output_port (output_port)
   );
endmodule

// File: tb/tb_mc_mem_sequencer.sv
// tb_mc_mem_sequencer: transaction-level expectations checked every cycle on
// the main instance, plus a narrow instance for counter wrap and select range.
module tb_mc_mem_sequencer;
   localparam int T = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   mc_mem_sequencer_if #(.W(16)) core();
   wire  [15:0] data;
   logic        read_m, write_m, mem_ready, wwd_valid;
   logic [15:0] address, wwd_data, num_inst, r_bus;
   logic [1:0]  wwd_sel;
   logic [63:0] output_port;

   mc_mem_sequencer_if #(.W(4)) c2();
   wire  [3:0]  data2;
   logic        read2, write2, ready2, wwd_valid2;
   logic        b2_en = 1'b1;
   logic [3:0]  address2, wwd_data2, num2;
   logic [2:0]  wwd_sel2;
   logic [19:0] port2;

   logic             e_ready, e_rv, e_err, e_rm, e_wm;
   logic [15:0]      e_rdata, e_addr, e_wd, e_ni;
   logic [3:0][15:0] e_port;
   int n_chk = 0, n_pass = 0, rm_cnt = 0;

   assign data  = e_wm ? 16'bz : r_bus;
   assign data2 = b2_en ? 4'h5 : 4'bz;

   mc_mem_sequencer #(.WORD_SIZE(16), .NUM_OUT_PORTS(4), .TIMEOUT(T)) dut (
      .clk(clk), .reset_n(reset_n), .core(core), .read_m(read_m), .write_m(write_m),
      .address(address), .data(data), .mem_ready(mem_ready), .wwd_valid(wwd_valid),
      .wwd_sel(wwd_sel), .wwd_data(wwd_data), .output_port(output_port), .num_inst(num_inst)
   );

   mc_mem_sequencer #(.WORD_SIZE(4), .NUM_OUT_PORTS(5), .TIMEOUT(15)) dut2 (
      .clk(clk), .reset_n(reset_n), .core(c2), .read_m(read2), .write_m(write2),
      .address(address2), .data(data2), .mem_ready(ready2), .wwd_valid(wwd_valid2),
      .wwd_sel(wwd_sel2), .wwd_data(wwd_data2), .output_port(port2), .num_inst(num2)
   );

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (read_m) rm_cnt++;
      chk("req_ready", 64'(core.req_ready), 64'(e_ready));
      chk("rsp_valid", 64'(core.rsp_valid), 64'(e_rv));
      if (e_rv) chk("rsp_err", 64'(core.rsp_err), 64'(e_err));
      chk("rsp_rdata", 64'(core.rsp_rdata), 64'(e_rdata));
      chk("read_m", 64'(read_m), 64'(e_rm));
      chk("write_m", 64'(write_m), 64'(e_wm));
      chk("address", 64'(address), 64'(e_addr));
      chk("data", 64'(data), 64'(e_wm ? e_wd : r_bus));
      chk("output_port", output_port, 64'(e_port));
      chk("num_inst", 64'(num_inst), 64'(e_ni));
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (wwd_valid) e_port[wwd_sel] = wwd_data;
      wwd_valid = 1'b0;
      e_rv = 1'b0;
   endtask

   // d = number of access cycles until mem_ready is seen; beyond T it times out
   task automatic access(input bit w, input bit f, input logic [15:0] a,
                         input logic [15:0] wd, input int d, input logic [15:0] rd);
      bit to;
      int n;
      to = d > T;
      n  = to ? T : d;
      core.req_valid = 1'b1;
      core.req_write = w;
      core.req_is_fetch = f;
      core.req_addr = a;
      core.req_wdata = wd;
      step();
      core.req_valid = 1'b0;
      e_ready = 1'b0; e_rm = !w; e_wm = w; e_addr = a; e_wd = wd;
      for (int i = 1; i <= n; i++) begin
         mem_ready = (i == d);
         r_bus = (!w && i == d) ? rd : 16'h0;
         step();
      end
      mem_ready = 1'b0;
      r_bus = 16'h0;
      e_ready = 1'b1; e_rm = 1'b0; e_wm = 1'b0; e_addr = 16'h0;
      e_rv = 1'b1; e_err = to;
      if (to) e_rdata = 16'h0;
      else if (!w) e_rdata = rd;
      if (!to && !w && f) e_ni++;
   endtask

   task automatic acc2(input bit f);
      c2.req_valid = 1'b1;
      c2.req_is_fetch = f;
      @(posedge clk); #1;
      c2.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("u2_rsp_valid", 64'(c2.rsp_valid), 64'd1);
      chk("u2_rsp_rdata", 64'(c2.rsp_rdata), 64'h5);
   endtask

   task automatic wwd2(input logic [2:0] s, input logic [3:0] v);
      wwd_valid2 = 1'b1; wwd_sel2 = s; wwd_data2 = v;
      @(posedge clk); #1;
      wwd_valid2 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      core.req_valid = 0; core.req_write = 0; core.req_is_fetch = 0;
      core.req_addr = 0; core.req_wdata = 0;
      mem_ready = 0; wwd_valid = 0; wwd_sel = 0; wwd_data = 0; r_bus = 0;
      c2.req_valid = 0; c2.req_write = 0; c2.req_is_fetch = 0;
      c2.req_addr = 4'h3; c2.req_wdata = 0;
      ready2 = 1; wwd_valid2 = 0; wwd_sel2 = 0; wwd_data2 = 0;
      e_ready = 1; e_rv = 0; e_err = 0; e_rm = 0; e_wm = 0;
      e_rdata = 0; e_addr = 0; e_wd = 0; e_ni = 0; e_port = '0;
      #1 reset_n = 1'b0;
      #1;
      chk("reset_req_ready", 64'(core.req_ready), 64'd1);
      chk("reset_num_inst", 64'(num_inst), 64'd0);
      chk("reset_output_port", output_port, 64'd0);
      repeat (2) step();
      reset_n = 1'b1;
      step();

      rm_cnt = 0;
      access(0, 0, 16'h0100, 16'h0F0F, 3, 16'h1234);
      chk("read_rdata_lit", 64'(core.rsp_rdata), 64'h1234);
      chk("read_valid_lit", 64'(core.rsp_valid), 64'd1);
      chk("read_m_cycles_lit", 64'(rm_cnt), 64'd3);

      wwd_valid = 1; wwd_sel = 2; wwd_data = 16'hAAAA;
      access(1, 0, 16'h0040, 16'hBEEF, 2, 16'h0);
      chk("port_lit", output_port, 64'h0000_AAAA_0000_0000);
      chk("rdata_held_lit", 64'(core.rsp_rdata), 64'h1234);
      step();

      access(0, 1, 16'h0200, 16'h0F0F, 1, 16'hCAFE);
      access(0, 1, 16'h0202, 16'h0F0F, 2, 16'h0001);
      step();

      rm_cnt = 0;
      access(0, 1, 16'h0300, 16'h0F0F, 9, 16'h7777);
      chk("timeout_err_lit", 64'(core.rsp_err), 64'd1);
      chk("timeout_rdata_lit", 64'(core.rsp_rdata), 64'd0);
      chk("timeout_num_inst_lit", 64'(num_inst), 64'd2);
      chk("timeout_cycles_lit", 64'(rm_cnt), 64'd4);
      access(0, 1, 16'h0302, 16'h0F0F, T, 16'h4444);
      chk("edge_ready_err_lit", 64'(core.rsp_err), 64'd0);
      chk("edge_ready_ni_lit", 64'(num_inst), 64'd3);
      access(1, 0, 16'h0304, 16'h1111, T + 1, 16'h0);

      mem_ready = 1; step(); step(); mem_ready = 0; step();

      wwd_valid = 1; wwd_sel = 0; wwd_data = 16'h1357;
      access(0, 0, 16'h0400, 16'h0F0F, 2, 16'h5A5A);
      wwd_valid = 1; wwd_sel = 3; wwd_data = 16'hC3C3;
      step();
      chk("data_read_ni_lit", 64'(num_inst), 64'd3);
      chk("ports_lit", output_port, 64'hC3C3_AAAA_0000_1357);

      core.req_valid = 1; core.req_write = 1; core.req_addr = 16'h0080; core.req_wdata = 16'h2222;
      step();
      core.req_valid = 0; core.req_write = 0;
      e_ready = 0; e_wm = 1; e_addr = 16'h0080; e_wd = 16'h2222;
      step();
      #2;
      reset_n = 1'b0;
      e_ready = 1; e_wm = 0; e_rm = 0; e_addr = 0; e_rdata = 0; e_ni = 0; e_port = '0;
      #1;
      chk("async_write_m_lit", 64'(write_m), 64'd0);
      chk("async_data_lit", 64'(data), 64'd0);
      chk("async_port_lit", output_port, 64'd0);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (3) step();
      chk("no_rsp_after_reset_lit", 64'(core.rsp_valid), 64'd0);
      access(0, 1, 16'h0500, 16'h0F0F, 1, 16'h2468);
      chk("post_reset_ni_lit", 64'(num_inst), 64'd1);
      step();

      for (int i = 1; i <= 15; i++) begin
         acc2(1);
         chk("u2_num_inst", 64'(num2), 64'(i % 16));
      end
      chk("u2_ni_max_lit", 64'(num2), 64'hF);
      acc2(1);
      chk("u2_ni_wrap_lit", 64'(num2), 64'h0);
      acc2(0);
      chk("u2_ni_data_read_lit", 64'(num2), 64'h0);
      chk("u2_err_lit", 64'(c2.rsp_err), 64'd0);
      wwd2(3'd2, 4'hA);
      wwd2(3'd5, 4'h3);
      wwd2(3'd7, 4'h7);
      chk("u2_port_oob_lit", 64'(port2), 64'h00A00);
      wwd2(3'd4, 4'h9);
      wwd2(3'd0, 4'h1);
      chk("u2_port_lit", 64'(port2), 64'h90A01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
